bram32_lsu: RTL and testbench
=============================

Name: bram32_lsu

Overview:
- Load/store requester that drives the 32-bit subword-addressable BRAM port: word address, write data, write enable, write subaddress; consumes registered read data.
- Accepts byte-addressed byte/half/word loads and stores over a valid/ready handshake.
- Generates the subword write code for stores; extracts, aligns and sign/zero-extends load data; returns one response per request.
- Sits between the CPU memory stage (or a test harness) and one BRAM instance.

Parameters:
- DEPTH, 512, BRAM depth in 32-bit words; must match the attached memory.
- ADDR_WIDTH, $clog2(DEPTH), localparam; word-address width. The byte address is ADDR_WIDTH+2 bits.

Ports:
- i_clk  in  1  clock; all logic on posedge.
- i_rst  in  1  synchronous active-high reset.
- i_req_valid  in  1  request valid.
- o_req_ready  out  1  high only in IDLE.
- i_req_addr  in  ADDR_WIDTH+2  byte address.
- i_req_we  in  1  1 = store, 0 = load.
- i_req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal.
- i_req_unsigned  in  1  load zero-extend when 1, sign-extend when 0.
- i_req_wdata  in  32  store data, LSB-justified.
- o_resp_valid  out  1  response valid; held until accepted.
- i_resp_ready  in  1  response accept.
- o_resp_rdata  out  32  load result; 0 for stores and errors.
- o_resp_err  out  1  misaligned access or illegal size.
- o_mem_addr  out  ADDR_WIDTH  BRAM word address.
- o_mem_wdata  out  32  BRAM write data.
- o_mem_we  out  1  BRAM write enable.
- o_mem_wr_subaddr  out  3  subword code: 1 = word, 2/3 = half0/half1, 4..7 = byte0..3; 0 when idle.
- i_mem_rdata  in  32  BRAM read data, valid one cycle after the address is presented.

Behaviour:
- Reset: state IDLE, o_req_ready=1; o_resp_valid, o_resp_err, o_resp_rdata, o_mem_we, o_mem_wr_subaddr, o_mem_addr and o_mem_wdata all 0.
- All o_mem_* and o_resp_* are registered outputs.
- FSM states: IDLE, ACCESS, LWAIT, RESP.
- IDLE: on valid&ready, latch the request.
  - Illegal size or misaligned (half with addr[0]=1; word with addr[1:0]!=0): go to RESP with err=1. No memory access.
  - Otherwise go to ACCESS.
- ACCESS (1 cycle): o_mem_addr = addr[ADDR_WIDTH+1:2].
  - Store: o_mem_we=1; o_mem_wdata = wdata; subaddr = 1 (word), 2+addr[1] (half), 4+addr[1:0] (byte). Go to RESP.
  - Load: o_mem_we=0. Go to LWAIT.
- LWAIT: capture i_mem_rdata >> (8*addr[1:0]); mask to size; extend per i_req_unsigned into o_resp_rdata. Go to RESP.
- RESP: o_resp_valid=1 with stable data/err until i_resp_ready. On handshake: valid=0, return to IDLE, ready=1 next cycle.
- Latency, accept edge = T:
  - Error response valid at T+1.
  - Store: write at edge T+1, response valid at T+2.
  - Load: response valid at T+3.
  - Best-case throughput: one request per 3 cycles (store) or 4 cycles (load).
- o_mem_we and o_mem_wr_subaddr are high/nonzero for exactly one cycle per store (per byte under the optional feature). They are 0 in every other cycle.
- o_resp_rdata is 0 for stores and errors.
- Reset mid-operation returns to IDLE and clears outputs at the next edge.
  - A write already on o_mem_we in the reset cycle completes at that edge.
  - No response is issued for the aborted request.
- i_resp_ready while o_resp_valid=0 is ignored.
- i_req_valid outside IDLE is ignored (ready=0).

Optional Feature:
- Macro: BRAM32_LSU_MISALIGNED_EN.
- Defined:
  - Misaligned half/word accesses are not errors. They are split into 2 or 4 sequential byte accesses at addr, addr+1, and so on, each running ACCESS (and LWAIT for loads).
  - Byte address increments modulo 2^(ADDR_WIDTH+2), wrapping to 0 at the top.
  - Store bytes are taken from wdata[7:0], [15:8], ... in little-endian order.
  - Load bytes are assembled little-endian, then extended.
  - A single response is issued after the last byte. Size 3 remains an error.
- Undefined: misaligned requests return err=1 with no memory access, as specified in Behaviour.

Test Plan:
- Word store then load: store addr 0x010, data 0xDEADBEEF -> one cycle we=1, mem_addr=4, subaddr=1. Load word 0x010 -> rdata 0xDEADBEEF, err=0, valid at T+3.
- Byte/half stores: sb 0x013 data 0x000000AA -> subaddr=7, wdata[7:0]=0xAA. sh 0x012 data 0x1234 -> subaddr=3. Load word 0x010 -> 0x12345678 given prior word 0x??345678; verify only the addressed lanes change.
- Sign extension: word at 0x020 = 0x80FF7F01. lb 0x021 -> 0x0000007F; lb 0x022 -> 0xFFFFFFFF; lbu 0x023 -> 0x00000080; lh 0x022 -> 0xFFFF80FF; lhu 0x022 -> 0x000080FF.
- Misaligned/illegal (feature off): lw 0x011 -> err=1, rdata=0, valid at T+1, no we. size=3 -> err=1.
- Backpressure: hold i_resp_ready=0 for 5 cycles on a load -> valid, rdata and ready stay stable; next request accepted only the cycle after the handshake.
- Reset mid-load: assert i_rst in LWAIT -> next cycle o_resp_valid=0, o_req_ready=1, subaddr=0, no response. Feature on: lw 0x7FF with DEPTH=512 reads bytes 0x7FF, 0x000, 0x001, 0x002 -> single response, little-endian assembled.

Source files
------------

// File: rtl/bram32_lsu.sv
// bram32_lsu: byte/half/word load-store requester for a 32-bit subword BRAM.
// Define BRAM32_LSU_MISALIGNED_EN to split misaligned accesses into bytes.
module bram32_lsu #(
  parameter  int DEPTH      = 512,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic [ADDR_WIDTH+1:0] i_req_addr,
  input  logic                  i_req_we,
  input  logic [1:0]            i_req_size,
  input  logic                  i_req_unsigned,
  input  logic [31:0]           i_req_wdata,
  output logic                  o_resp_valid,
  input  logic                  i_resp_ready,
  output logic [31:0]           o_resp_rdata,
  output logic                  o_resp_err,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [31:0]           o_mem_wdata,
  output logic                  o_mem_we,
  output logic [2:0]            o_mem_wr_subaddr,
  input  logic [31:0]           i_mem_rdata
);

  localparam int BW = ADDR_WIDTH + 2;

  typedef enum logic [1:0] {
    IDLE, ACCESS, LWAIT, RESP
  } state_t;

  state_t          r_state;
  logic [BW-1:0]   r_addr;
  logic            r_we;
  logic [1:0]      r_size;
  logic            r_uns;
  logic [31:0]     r_wdata;
  logic            r_split;
  logic [1:0]      r_idx;
  logic [31:0]     r_acc;

  logic            w_misal;
  logic            w_ill;
  logic            w_err;
  logic            w_split;
  logic            w_last;
  logic [BW-1:0]   w_next;
  logic [1:0]      w_nidx;
  logic [31:0]     w_lane;
  logic [31:0]     w_acc;

  always_comb begin
    w_misal = (i_req_size == 2'd1 && i_req_addr[0]) ||
              (i_req_size == 2'd2 && i_req_addr[1:0] != 2'b00);
    w_ill   = (i_req_size == 2'd3);
`ifdef BRAM32_LSU_MISALIGNED_EN
    w_split = w_misal;
    w_err   = w_ill;
`else
    w_split = 1'b0;
    w_err   = w_ill | w_misal;
`endif
    w_last = !r_split ||
             (r_idx == ((r_size == 2'd2) ? 2'd3 : 2'd1));
    w_next = r_addr + BW'(1);
    w_nidx = r_idx + 2'd1;
    w_lane = i_mem_rdata >> {r_addr[1:0], 3'b000};
    w_acc  = r_acc | ({24'd0, w_lane[7:0]} << {r_idx, 3'b000});
  end

  function automatic logic [2:0] subcode(
    input logic [1:0] sz,
    input logic [1:0] a,
    input logic       split
  );
    if (split) return {1'b1, a};
    case (sz)
      2'd2:    return 3'd1;
      2'd1:    return {2'b01, a[1]};
      default: return {1'b1, a};
    endcase
  endfunction

  function automatic logic [31:0] ext(
    input logic [31:0] v,
    input logic [1:0]  sz,
    input logic        u
  );
    case (sz)
      2'd0:    return u ? {24'd0, v[7:0]}
                        : {{24{v[7]}}, v[7:0]};
      2'd1:    return u ? {16'd0, v[15:0]}
                        : {{16{v[15]}}, v[15:0]};
      default: return v;
    endcase
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state          <= IDLE;
      r_addr           <= '0;
      r_we             <= 1'b0;
      r_size           <= 2'd0;
      r_uns            <= 1'b0;
      r_wdata          <= 32'd0;
      r_split          <= 1'b0;
      r_idx            <= 2'd0;
      r_acc            <= 32'd0;
      o_req_ready      <= 1'b1;
      o_resp_valid     <= 1'b0;
      o_resp_err       <= 1'b0;
      o_resp_rdata     <= 32'd0;
      o_mem_addr       <= '0;
      o_mem_wdata      <= 32'd0;
      o_mem_we         <= 1'b0;
      o_mem_wr_subaddr <= 3'd0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (i_req_valid) begin
            r_addr      <= i_req_addr;
            r_we        <= i_req_we;
            r_size      <= i_req_size;
            r_uns       <= i_req_unsigned;
            r_wdata     <= i_req_wdata;
            r_split     <= w_split;
            r_idx       <= 2'd0;
            r_acc       <= 32'd0;
            o_req_ready <= 1'b0;
            if (w_err) begin
              r_state      <= RESP;
              o_resp_valid <= 1'b1;
              o_resp_err   <= 1'b1;
              o_resp_rdata <= 32'd0;
            end else begin
              r_state          <= ACCESS;
              o_mem_addr       <= i_req_addr[BW-1:2];
              o_mem_we         <= i_req_we;
              o_mem_wdata      <= i_req_wdata;
              o_mem_wr_subaddr <= i_req_we ?
                subcode(i_req_size, i_req_addr[1:0], w_split) : 3'd0;
            end
          end
        end
        ACCESS: begin
          o_mem_we         <= 1'b0;
          o_mem_wr_subaddr <= 3'd0;
          if (!r_we) begin
            r_state <= LWAIT;
          end else if (w_last) begin
            r_state      <= RESP;
            o_resp_valid <= 1'b1;
            o_resp_err   <= 1'b0;
            o_resp_rdata <= 32'd0;
          end else begin
            // next byte of a split store, issued back to back
            r_addr           <= w_next;
            r_idx            <= w_nidx;
            o_mem_addr       <= w_next[BW-1:2];
            o_mem_we         <= 1'b1;
            o_mem_wr_subaddr <= {1'b1, w_next[1:0]};
            o_mem_wdata      <= r_wdata >> {w_nidx, 3'b000};
          end
        end
        LWAIT: begin
          if (w_last) begin
            r_state      <= RESP;
            o_resp_valid <= 1'b1;
            o_resp_err   <= 1'b0;
            o_resp_rdata <= ext(r_split ? w_acc : w_lane,
                                r_size, r_uns);
          end else begin
            r_acc      <= w_acc;
            r_addr     <= w_next;
            r_idx      <= w_nidx;
            o_mem_addr <= w_next[BW-1:2];
            r_state    <= ACCESS;
          end
        end
        RESP: begin
          if (i_resp_ready) begin
            o_resp_valid <= 1'b0;
            o_resp_err   <= 1'b0;
            o_resp_rdata <= 32'd0;
            o_req_ready  <= 1'b1;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bram32_lsu.sv
// tb_bram32_lsu: directed + random checks of bram32_lsu against a byte-array
// reference model, with a subword BRAM model attached to the memory port.
module tb_bram32_lsu;

  localparam int DEPTH = 512;
  localparam int AW    = 9;
  localparam int NB    = DEPTH * 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW+1:0] req_addr = '0;
  logic          req_we = 1'b0;
  logic [1:0]    req_size = 2'd0;
  logic          req_uns = 1'b0;
  logic [31:0]   req_wdata = 32'd0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_we;
  logic [2:0]    mem_sub;
  logic [31:0]   mem_rdata = 32'd0;

  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  bram32_lsu #(.DEPTH(DEPTH)) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_req_valid      (req_valid),
    .o_req_ready      (req_ready),
    .i_req_addr       (req_addr),
    .i_req_we         (req_we),
    .i_req_size       (req_size),
    .i_req_unsigned   (req_uns),
    .i_req_wdata      (req_wdata),
    .o_resp_valid     (resp_valid),
    .i_resp_ready     (resp_ready),
    .o_resp_rdata     (resp_rdata),
    .o_resp_err       (resp_err),
    .o_mem_addr       (mem_addr),
    .o_mem_wdata      (mem_wdata),
    .o_mem_we         (mem_we),
    .o_mem_wr_subaddr (mem_sub),
    .i_mem_rdata      (mem_rdata)
  );

  // Attached BRAM: registered read, subword-coded writes
  logic [31:0]   bram [DEPTH];
  int            wr_cnt   = 0;
  int            sub_viol = 0;
  logic [AW-1:0] l_addr   = '0;
  logic [2:0]    l_sub    = 3'd0;
  logic [31:0]   l_wd     = 32'd0;

  always @(posedge clk) begin
    if (mem_we) begin
      case (mem_sub)
        3'd1: bram[mem_addr] <= mem_wdata;
        3'd2: bram[mem_addr][15:0] <= mem_wdata[15:0];
        3'd3: bram[mem_addr][31:16] <= mem_wdata[15:0];
        3'd4, 3'd5, 3'd6, 3'd7:
          bram[mem_addr][{mem_sub[1:0], 3'b000} +: 8] <= mem_wdata[7:0];
        default: ;
      endcase
      wr_cnt <= wr_cnt + 1;
      l_addr <= mem_addr;
      l_sub  <= mem_sub;
      l_wd   <= mem_wdata;
    end
    if (mem_we != (mem_sub != 3'd0)) sub_viol <= sub_viol + 1;
    mem_rdata <= bram[mem_addr];
  end

  logic [7:0] ref_mem [NB];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input bit we, input int sz, input bit uns,
                        input int addr, input logic [31:0] wd,
                        input int bp, output logic [31:0] got);
    int nb, lat, w0, el, ew;
    bit mis, eerr, split;
    logic [31:0] er;
    nb  = (sz == 3) ? 1 : (1 << sz);
    mis = (sz == 1 && addr % 2 != 0) || (sz == 2 && addr % 4 != 0);
`ifdef BRAM32_LSU_MISALIGNED_EN
    eerr  = (sz == 3);
    split = mis;
`else
    eerr  = (sz == 3) || mis;
    split = 1'b0;
`endif
    er = 32'd0;
    ew = 0;
    if (eerr) begin
      el = 1;
    end else if (we) begin
      el = split ? nb + 1 : 2;
      ew = split ? nb : 1;
      for (int i = 0; i < nb; i++)
        ref_mem[(addr + i) % NB] = wd[8*i +: 8];
    end else begin
      el = split ? 2 * nb + 1 : 3;
      for (int i = nb - 1; i >= 0; i--)
        er = (er << 8) | 32'(ref_mem[(addr + i) % NB]);
      if (!uns && nb < 4 && er[8*nb-1])
        er = er - (32'd1 << (8 * nb));
    end

    @(negedge clk);
    chk("req_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_size  = 2'(sz);
    req_uns   = uns;
    req_addr  = (AW+2)'(addr);
    req_wdata = wd;
    w0        = wr_cnt;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!resp_valid && lat < 40);
    got = resp_rdata;
    chk("latency", 32'(lat), 32'(el));
    chk("rdata", resp_rdata, er);
    chk("err", 32'(resp_err), 32'(eerr));
    for (int i = 0; i < bp; i++) begin
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_size  = 2'd2;
      req_addr  = '0;
      @(negedge clk);
      chk("bp_valid", 32'(resp_valid), 32'd1);
      chk("bp_rdata", resp_rdata, er);
      chk("bp_ready", 32'(req_ready), 32'd0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    chk("hs_valid", 32'(resp_valid), 32'd0);
    chk("hs_ready", 32'(req_ready), 32'd1);
    chk("writes", 32'(wr_cnt - w0), 32'(ew));
  endtask

  initial begin
    logic [31:0] got;
    int sz, a;
    for (int i = 0; i < NB; i++) ref_mem[i] = 8'h00;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_valid", 32'(resp_valid), 32'd0);
    chk("rst_err", 32'(resp_err), 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_sub", 32'(mem_sub), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    rst = 1'b0;

    for (int w = 0; w < 64; w++)
      do_req(1'b1, 2, 1'b0, w * 4, $urandom, 0, got);
    do_req(1'b1, 2, 1'b0, 'h7FC, $urandom, 0, got);

    do_req(1'b1, 2, 1'b0, 'h010, 32'hDEADBEEF, 0, got);
    chk("sw_addr", 32'(l_addr), 32'd4);
    chk("sw_sub", 32'(l_sub), 32'd1);
    chk("sw_wdata", l_wd, 32'hDEADBEEF);
    do_req(1'b0, 2, 1'b0, 'h010, 32'd0, 0, got);
    chk("lw_dead", got, 32'hDEADBEEF);

    do_req(1'b1, 2, 1'b0, 'h010, 32'h11345678, 0, got);
    do_req(1'b1, 0, 1'b0, 'h013, 32'h000000AA, 0, got);
    chk("sb_sub", 32'(l_sub), 32'd7);
    chk("sb_wdata", 32'(l_wd[7:0]), 32'hAA);
    do_req(1'b1, 1, 1'b0, 'h012, 32'h00001234, 0, got);
    chk("sh_sub", 32'(l_sub), 32'd3);
    do_req(1'b0, 2, 1'b0, 'h010, 32'd0, 0, got);
    chk("lw_merge", got, 32'h12345678);

    do_req(1'b1, 2, 1'b0, 'h020, 32'h80FF7F01, 0, got);
    do_req(1'b0, 0, 1'b0, 'h021, 32'd0, 0, got);
    chk("lb_21", got, 32'h0000007F);
    do_req(1'b0, 0, 1'b0, 'h022, 32'd0, 0, got);
    chk("lb_22", got, 32'hFFFFFFFF);
    do_req(1'b0, 0, 1'b1, 'h023, 32'd0, 0, got);
    chk("lbu_23", got, 32'h00000080);
    do_req(1'b0, 1, 1'b0, 'h022, 32'd0, 0, got);
    chk("lh_22", got, 32'hFFFF80FF);
    do_req(1'b0, 1, 1'b1, 'h022, 32'd0, 0, got);
    chk("lhu_22", got, 32'h000080FF);

`ifdef BRAM32_LSU_MISALIGNED_EN
    do_req(1'b1, 2, 1'b0, 'h7FE, 32'hA1B2C3D4, 1, got);
    do_req(1'b0, 2, 1'b0, 'h7FF, 32'd0, 0, got);
    do_req(1'b0, 1, 1'b0, 'h011, 32'd0, 0, got);
`else
    do_req(1'b0, 2, 1'b0, 'h011, 32'd0, 0, got);
    chk("mis_rdata", got, 32'd0);
    do_req(1'b1, 1, 1'b0, 'h013, 32'hFFFF, 0, got);
`endif
    do_req(1'b0, 3, 1'b0, 'h010, 32'd0, 0, got);
    do_req(1'b1, 3, 1'b0, 'h014, 32'h55, 0, got);

    do_req(1'b0, 2, 1'b0, 'h010, 32'd0, 5, got);
    chk("bp_lw", got, 32'h12345678);

    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_size  = 2'd2;
    req_addr  = 'h010;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mr_valid", 32'(resp_valid), 32'd0);
    chk("mr_ready", 32'(req_ready), 32'd1);
    chk("mr_sub", 32'(mem_sub), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("mr_noresp", 32'(resp_valid), 32'd0);
    end

    for (int n = 0; n < 60; n++) begin
      sz = ($urandom % 10 == 0) ? 3 : int'($urandom % 3);
      a  = int'($urandom % 248);
      do_req(1'($urandom), sz, 1'($urandom), a, $urandom,
             int'($urandom % 3), got);
    end

    @(negedge clk);
    chk("strobe_rule", 32'(sub_viol), 32'd0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
